// File: rtl/alu_accumulator.sv
// Execute-stage ALU and accumulator: single-cycle MOV/arithmetic/logic ops on AR and
// Flags, plus a serial shift-add multiplier that writes {AH, AR} after DATA_WIDTH steps.

`ifndef ALU_ACCUMULATOR_DEFS
`define ALU_ACCUMULATOR_DEFS
`define ZERO          0
`define CARRY         1
`define NEG           2
`define OV            3
`define ALU_OPER2_BIT 2
`define LOAD_I        3'b000
`define LOAD_X        3'b001
`endif

module alu_accumulator #(
    parameter int DATA_WIDTH      = 8,
    parameter int INST_DATA_WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       arst,
    input  logic                       exec,
    input  logic [INST_DATA_WIDTH-1:0] ir,
    input  logic [INST_DATA_WIDTH-1:0] ibr,
    input  logic [DATA_WIDTH-1:0]      mem_data,
    output logic [DATA_WIDTH-1:0]      AR,
    output logic [DATA_WIDTH-1:0]      AH,
    output logic [3:0]                 Flags,
    output logic                       busy,
    output logic                       done
);
    localparam int W  = DATA_WIDTH;
    localparam int CW = $clog2(W + 1);

    typedef enum logic {S_IDLE, S_MUL} state_t;

    state_t        state;
    state_t        state_next;
    logic [CW-1:0] count;
    logic [W-1:0]  mcand;
    logic [W-1:0]  mplier;
    logic [2*W-1:0] prod;
    logic [2*W:0]   step_sum;
    logic [2*W-1:0] prod_next;
    logic           last_step;

    logic [1:0]   cls;
    logic [2:0]   op;
    logic [W-1:0] opb;
    logic         accept;
    logic         mul_start;
    logic         unused_ir;

    assign cls       = ir[7:6];
    assign op        = ir[5:3];
    assign opb       = ir[`ALU_OPER2_BIT] ? mem_data : W'(ibr);
    assign unused_ir = ^ir[1:0];

    // exec is only honoured while idle; anything arriving during a MUL is dropped.
    assign accept    = exec && (state == S_IDLE);
    assign mul_start = accept && (cls == 2'b01) && (op == 3'b100);
    assign last_step = (state == S_MUL) && (count == CW'(W - 1));

    // Right-shifting shift-add: add the multiplicand into the top half, then shift down.
    assign step_sum  = {1'b0, prod} + (mplier[0] ? {1'b0, mcand, {W{1'b0}}} : '0);
    assign prod_next = step_sum[2*W:1];

    always_ff @(posedge clk) begin
        if (arst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (mul_start) state_next = S_MUL;
            S_MUL:   if (last_step) state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        busy = (state == S_MUL);
        done = last_step;
    end

    logic [W-1:0] res;
    logic [W:0]   ext;
    logic [W-1:0] bb;
    logic         cin;
    logic         is_sub;
    logic         c_new;
    logic         v_new;
    logic         wr_ar;
    logic         wr_zn;
    logic         wr_cv;

    always_comb begin
        res    = '0;
        ext    = '0;
        bb     = opb;
        cin    = 1'b0;
        is_sub = 1'b0;
        c_new  = 1'b0;
        v_new  = 1'b0;
        wr_ar  = 1'b0;
        wr_zn  = 1'b0;
        wr_cv  = 1'b0;
        case (cls)
            2'b00: begin
                if (op == `LOAD_I) begin
                    res   = W'(ibr);
                    wr_ar = 1'b1;
                    wr_zn = 1'b1;
                end else if (op == `LOAD_X) begin
                    res   = mem_data;
                    wr_ar = 1'b1;
                    wr_zn = 1'b1;
                end
            end
            2'b01: begin
                // INC/DEC are ADD/SUB with B forced to 1 so carry and overflow follow the same rules.
                if (op == 3'b101 || op == 3'b110) bb = W'(1);
                cin    = (op == 3'b001 || op == 3'b011) ? Flags[`CARRY] : 1'b0;
                is_sub = (op == 3'b010 || op == 3'b011 || op == 3'b110 || op == 3'b111);
                if (is_sub) ext = {1'b0, AR} - {1'b0, bb} - {{W{1'b0}}, cin};
                else        ext = {1'b0, AR} + {1'b0, bb} + {{W{1'b0}}, cin};
                res   = ext[W-1:0];
                c_new = ext[W];
                if (is_sub) v_new = (AR[W-1] != bb[W-1]) && (res[W-1] != AR[W-1]);
                else        v_new = (AR[W-1] == bb[W-1]) && (res[W-1] != AR[W-1]);
                wr_zn = (op != 3'b100);
                wr_cv = (op != 3'b100);
                wr_ar = (op != 3'b100) && (op != 3'b111);
            end
            2'b10: begin
                case (op)
                    3'b000: res = AR & opb;
                    3'b001: res = AR | opb;
                    3'b010: res = AR ^ opb;
                    3'b011: res = ~AR;
                    3'b100: begin res = {AR[W-2:0], 1'b0};     c_new = AR[W-1]; end
                    3'b101: begin res = {1'b0, AR[W-1:1]};     c_new = AR[0];   end
                    3'b110: begin res = {AR[W-2:0], AR[W-1]};  c_new = AR[W-1]; end
                    default: begin res = {AR[0], AR[W-1:1]};   c_new = AR[0];   end
                endcase
                wr_ar = 1'b1;
                wr_zn = 1'b1;
                wr_cv = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (arst) begin
            AR     <= '0;
            AH     <= '0;
            Flags  <= '0;
            mcand  <= '0;
            mplier <= '0;
            prod   <= '0;
            count  <= '0;
        end else if (state == S_MUL) begin
            prod   <= prod_next;
            mplier <= mplier >> 1;
            count  <= count + 1'b1;
            if (last_step) begin
                AR            <= prod_next[W-1:0];
                AH            <= prod_next[2*W-1:W];
                Flags[`ZERO]  <= (prod_next == '0);
                Flags[`NEG]   <= prod_next[2*W-1];
                Flags[`CARRY] <= |prod_next[2*W-1:W];
                Flags[`OV]    <= |prod_next[2*W-1:W];
            end
        end else if (accept) begin
            if (mul_start) begin
                mcand  <= AR;
                mplier <= opb;
                prod   <= '0;
                count  <= '0;
            end
            if (wr_ar) AR <= res;
            if (wr_zn) begin
                Flags[`ZERO] <= (res == '0);
                Flags[`NEG]  <= res[W-1];
            end
            if (wr_cv) begin
                Flags[`CARRY] <= c_new;
                Flags[`OV]    <= v_new;
            end
        end
    end

endmodule

// File: tb/tb_alu_accumulator.sv
// Randomised bench for alu_accumulator against an integer-arithmetic reference model.

module tb_alu_accumulator;
  logic       clk = 1'b0;
  logic       arst;
  logic       exec;
  logic [7:0] ir;
  logic [7:0] ibr;
  logic [7:0] mem_data;
  logic [7:0] AR;
  logic [7:0] AH;
  logic [3:0] Flags;
  logic       busy;
  logic       done;

  int         n_checks = 0;
  int         n_fail   = 0;

  // reference model state; flag bits: 0=Z 1=C 2=N 3=V
  int         m_ar = 0;
  int         m_ah = 0;
  logic [3:0] m_flags = 4'h0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  alu_accumulator #(.DATA_WIDTH(8), .INST_DATA_WIDTH(8)) dut (
    .clk      (clk),
    .arst     (arst),
    .exec     (exec),
    .ir       (ir),
    .ibr      (ibr),
    .mem_data (mem_data),
    .AR       (AR),
    .AH       (AH),
    .Flags    (Flags),
    .busy     (busy),
    .done     (done)
  );

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] mk(input int cls, input int op, input int sel);
    logic [1:0] c2;
    logic [2:0] o3;
    c2 = cls[1:0];
    o3 = op[2:0];
    return {c2, o3, sel[0], 2'b00};
  endfunction

  function automatic int sgn(input int v);
    return (v > 127) ? v - 256 : v;
  endfunction

  function automatic void set_zn(input int r);
    m_flags[0] = (r == 0);
    m_flags[2] = (r > 127);
  endfunction

  // Non-MUL instruction effect computed with plain integer arithmetic.
  function automatic void model_exec(input logic [7:0] i, input logic [7:0] imm, input logic [7:0] mem);
    int a, b, r, sr, cin, c;
    int cls, op;
    a   = m_ar;
    cls = int'(i[7:6]);
    op  = int'(i[5:3]);
    b   = i[2] ? int'(mem) : int'(imm);
    cin = int'(m_flags[1]);
    c   = 0;
    sr  = 0;
    r   = 0;
    case (cls)
      0: begin
        if (op == 0)      r = int'(imm);
        else if (op == 1) r = int'(mem);
        else return;
        m_ar = r;
        set_zn(r);
      end
      1: begin
        case (op)
          0: begin r = a + b;       sr = sgn(a) + sgn(b);       c = (r > 255); end
          1: begin r = a + b + cin; sr = sgn(a) + sgn(b) + cin; c = (r > 255); end
          2: begin r = a - b;       sr = sgn(a) - sgn(b);       c = (r < 0);   end
          3: begin r = a - b - cin; sr = sgn(a) - sgn(b) - cin; c = (r < 0);   end
          5: begin r = a + 1;       sr = sgn(a) + 1;            c = (r > 255); end
          6: begin r = a - 1;       sr = sgn(a) - 1;            c = (r < 0);   end
          7: begin r = a - b;       sr = sgn(a) - sgn(b);       c = (r < 0);   end
          default: return;
        endcase
        r = r & 255;
        if (op != 7) m_ar = r;
        set_zn(r);
        m_flags[1] = (c != 0);
        m_flags[3] = (sr > 127) || (sr < -128);
      end
      2: begin
        case (op)
          0: r = a & b;
          1: r = a | b;
          2: r = a ^ b;
          3: r = (~a) & 255;
          4: begin r = (a << 1) & 255;              c = a >> 7;  end
          5: begin r = a >> 1;                      c = a & 1;   end
          6: begin r = ((a << 1) | (a >> 7)) & 255; c = a >> 7;  end
          default: begin r = (a >> 1) | ((a & 1) << 7); c = a & 1; end
        endcase
        m_ar = r;
        set_zn(r);
        m_flags[1] = (c != 0);
        m_flags[3] = 1'b0;
      end
      default: ;
    endcase
  endfunction

  // ---------------- drivers ----------------
  task automatic issue(input logic [7:0] i, input logic [7:0] imm, input logic [7:0] mem);
    @(negedge clk);
    exec     = 1'b1;
    ir       = i;
    ibr      = imm;
    mem_data = mem;
    @(posedge clk);
    #1;
    exec     = 1'b0;
    ir       = 8'($urandom);
    ibr      = 8'($urandom);
    mem_data = 8'($urandom);
  endtask

  task automatic check_state(input string tag);
    check({tag, "_ar"},    AR,    m_ar);
    check({tag, "_ah"},    AH,    m_ah);
    check({tag, "_flags"}, Flags, m_flags);
    check({tag, "_busy"},  busy,  0);
  endtask

  task automatic do_op(input string tag, input logic [7:0] i, input logic [7:0] imm, input logic [7:0] mem);
    issue(i, imm, mem);
    model_exec(i, imm, mem);
    check_state(tag);
  endtask

  // poke = busy cycle (1..8) in which a stray exec is driven; 0 for none
  task automatic run_mul(input logic [7:0] i, input logic [7:0] imm, input logic [7:0] mem, input int poke);
    int a, b, p;
    int n_busy, n_done, guard;
    bit held;
    a      = m_ar;
    b      = i[2] ? int'(mem) : int'(imm);
    n_busy = 0;
    n_done = 0;
    guard  = 0;
    held   = 1'b1;
    issue(i, imm, mem);
    while (busy === 1'b1 && guard < 40) begin
      n_busy++;
      if (done === 1'b1) n_done++;
      if (AR !== 8'(m_ar) || Flags !== m_flags || AH !== 8'(m_ah)) held = 1'b0;
      if (n_busy == poke) begin
        exec     = 1'b1;
        ir       = 8'($urandom);
        ibr      = 8'($urandom);
        mem_data = 8'($urandom);
      end
      @(posedge clk);
      #1;
      exec = 1'b0;
      guard++;
    end
    p = a * b;
    m_ar       = p & 255;
    m_ah       = p >> 8;
    m_flags[0] = (p == 0);
    m_flags[2] = ((p >> 15) & 1) != 0;
    m_flags[1] = (m_ah != 0);
    m_flags[3] = (m_ah != 0);
    check("mul_busy_cycles", n_busy, 8);
    check("mul_done_pulses", n_done, 1);
    check("mul_hold", held, 1);
    check("mul_done_low", done, 0);
    check_state("mul");
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [7:0] ri;
    int         seen_done;
    arst     = 1'b1;
    exec     = 1'b0;
    ir       = 8'h00;
    ibr      = 8'h00;
    mem_data = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    arst = 1'b0;
    check_state("reset");
    check("reset_done", done, 0);

    // load then add: signed overflow into 0x80
    do_op("load_7f", mk(0, 0, 0), 8'h7F, 8'h00);
    do_op("add_ovf", mk(1, 0, 0), 8'h01, 8'h00);
    check("add_ovf_ar_const", AR, 8'h80);
    check("add_ovf_flags_const", Flags, 4'b1100);

    // borrow and compare
    do_op("load_00", mk(0, 0, 0), 8'h00, 8'h00);
    do_op("sub_mem", mk(1, 2, 1), 8'h00, 8'h01);
    check("sub_flags_const", Flags, 4'b0110);
    do_op("cmp_ff", mk(1, 7, 0), 8'hFF, 8'h00);
    check("cmp_ar_const", AR, 8'hFF);
    check("cmp_flags_const", Flags, 4'b0001);

    // carry chain
    do_op("load_ff", mk(0, 0, 0), 8'hFF, 8'h00);
    do_op("add_carry", mk(1, 0, 0), 8'h01, 8'h00);
    check("add_carry_flags_const", Flags, 4'b0011);
    do_op("adc", mk(1, 1, 0), 8'h00, 8'h00);
    check("adc_ar_const", AR, 8'h01);

    // shifts, rotates, not
    do_op("loadx_81", mk(0, 1, 0), 8'h00, 8'h81);
    do_op("shl", mk(2, 4, 0), 8'h00, 8'h00);
    check("shl_ar_const", AR, 8'h02);
    do_op("load_81", mk(0, 0, 0), 8'h81, 8'h00);
    do_op("ror", mk(2, 7, 0), 8'h00, 8'h00);
    check("ror_ar_const", AR, 8'hC0);
    do_op("load_0f", mk(0, 0, 0), 8'h0F, 8'h00);
    do_op("not", mk(2, 3, 0), 8'h00, 8'h00);
    check("not_flags_const", Flags, 4'b0100);

    // multiply
    do_op("load_0f_m", mk(0, 0, 0), 8'h0F, 8'h00);
    run_mul(mk(1, 4, 0), 8'h11, 8'h00, 0);
    check("mul1_ar_const", AR, 8'hFF);
    do_op("load_10", mk(0, 0, 0), 8'h10, 8'h00);
    run_mul(mk(1, 4, 0), 8'h10, 8'h00, 4);
    check("mul2_ah_const", AH, 8'h01);
    check("mul2_flags_const", Flags, 4'b1010);
    do_op("load_c3", mk(0, 0, 0), 8'hC3, 8'h00);
    run_mul(mk(1, 4, 1), 8'h00, 8'hE7, 8);

    // reset during an active multiply
    do_op("load_37", mk(0, 0, 0), 8'h37, 8'h00);
    issue(mk(1, 4, 0), 8'h5A, 8'h00);
    repeat (3) @(posedge clk);
    @(negedge clk);
    arst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    arst    = 1'b0;
    m_ar    = 0;
    m_ah    = 0;
    m_flags = 4'h0;
    check_state("mid_mul_reset");
    seen_done = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) seen_done++;
    end
    check("post_reset_quiet", seen_done, 0);
    @(posedge clk);
    #1;

    // randomized instruction stream
    for (int n = 0; n < 200; n++) begin
      ri = 8'($urandom);
      if (ri[7:6] == 2'b01 && ri[5:3] == 3'b100)
        run_mul(ri, 8'($urandom), 8'($urandom), int'($urandom_range(0, 8)));
      else
        do_op("rand", ri, 8'($urandom), 8'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
